// File: rtl/lutram_march_bist.sv
// March C- built-in self-test sequencer for a dual-port 2**A_WIDTH x 1 distributed RAM.
// Optional LUTRAM_BIST_ERRCNT_EN: never stop early, add err_count_o (saturating mismatch count).
module lutram_march_bist #(
  parameter int unsigned A_WIDTH = 7
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  output logic               ram_we_o,
  output logic               ram_d_o,
  output logic [A_WIDTH-1:0] ram_a_o,
  output logic [A_WIDTH-1:0] ram_dpra_o,
  input  logic               ram_spo_i,
  input  logic               ram_dpo_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               fail_o,
  output logic [2:0]         fail_elem_o,
  output logic [A_WIDTH-1:0] fail_addr_o,
  output logic [1:0]         fail_port_o
`ifdef LUTRAM_BIST_ERRCNT_EN
  ,
  output logic [7:0]         err_count_o
`endif
);

  localparam int unsigned ELEM_W = 3;
  localparam int unsigned ERR_W  = 8;
  localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ELEM_W-1:0]   elem_q, elem_d;
  logic [A_WIDTH-1:0]  addr_q, addr_d;
  logic                we_q, we_d;
  logic                d_q, d_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [ELEM_W-1:0]   fail_elem_q, fail_elem_d;
  logic [A_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [1:0]          fail_port_q, fail_port_d;
`ifdef LUTRAM_BIST_ERRCNT_EN
  logic [ERR_W-1:0]    err_q, err_d;
`endif

  logic                dir_up, next_up, at_end, rd_exp;
  logic [ELEM_W-1:0]   elem_inc;
  logic [A_WIDTH-1:0]  addr_step, next_start;
  logic [1:0]          mism;

  // Element geometry: M3/M4 run downwards; odd elements write 1 and read 0.
  always_comb begin
    elem_inc   = ELEM_W'(elem_q + ELEM_W'(1));
    dir_up     = !((elem_q == ELEM_W'(3)) || (elem_q == ELEM_W'(4)));
    next_up    = !((elem_inc == ELEM_W'(3)) || (elem_inc == ELEM_W'(4)));
    at_end     = dir_up ? (addr_q == '1) : (addr_q == '0);
    addr_step  = dir_up ? A_WIDTH'(addr_q + A_WIDTH'(1)) : A_WIDTH'(addr_q - A_WIDTH'(1));
    next_start = next_up ? '0 : '1;
    rd_exp     = ~elem_q[0];
    mism       = {ram_dpo_i != rd_exp, ram_spo_i != rd_exp};
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    fail_d      = fail_q;
    fail_elem_d = fail_elem_q;
    fail_addr_d = fail_addr_q;
    fail_port_d = fail_port_q;
`ifdef LUTRAM_BIST_ERRCNT_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_WR;
          elem_d      = '0;
          addr_d      = '0;
          fail_d      = 1'b0;
          fail_elem_d = '0;
          fail_addr_d = '0;
          fail_port_d = '0;
`ifdef LUTRAM_BIST_ERRCNT_EN
          err_d       = '0;
`endif
        end
      end
      S_WR: begin
        if (at_end) begin
          elem_d  = elem_inc;
          addr_d  = next_start;
          state_d = S_RD;
        end else begin
          addr_d  = addr_step;
          state_d = (elem_q == '0) ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (elem_q == LAST_ELEM) begin
          if (at_end) state_d = S_DONE;
          else        addr_d  = addr_step;
        end else begin
          state_d = S_WR;
        end
        if (|mism) begin
          fail_d = 1'b1;
          if (!fail_q) begin
            fail_elem_d = elem_q;
            fail_addr_d = addr_q;
            fail_port_d = mism;
          end
`ifdef LUTRAM_BIST_ERRCNT_EN
          if (err_q != '1) err_d = ERR_W'(err_q + ERR_W'(1));
`else
          state_d = S_DONE;
          addr_d  = addr_q;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with state_q.
    we_d   = (state_d == S_WR);
    d_d    = (state_d == S_WR) && elem_d[0];
    busy_d = (state_d == S_WR) || (state_d == S_RD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      d_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_elem_q <= '0;
      fail_addr_q <= '0;
      fail_port_q <= '0;
`ifdef LUTRAM_BIST_ERRCNT_EN
      err_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_elem_q <= fail_elem_d;
      fail_addr_q <= fail_addr_d;
      fail_port_q <= fail_port_d;
`ifdef LUTRAM_BIST_ERRCNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign ram_we_o    = we_q;
  assign ram_d_o     = d_q;
  assign ram_a_o     = addr_q;
  assign ram_dpra_o  = addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_elem_o = fail_elem_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_port_o = fail_port_q;
`ifdef LUTRAM_BIST_ERRCNT_EN
  assign err_count_o = err_q;
`endif

endmodule

// File: tb/tb_lutram_march_bist.sv
// Self-checking bench for lutram_march_bist: behavioural 128x1 RAM with injectable stuck-at read faults.
module tb_lutram_march_bist;

  localparam int unsigned AW    = 7;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned TOTAL = 10 * DEPTH;

  logic          clk = 1'b0;
  logic          rst_ni, start_i;
  logic          ram_we_o, ram_d_o, ram_spo_i, ram_dpo_i;
  logic [AW-1:0] ram_a_o, ram_dpra_o, fail_addr_o;
  logic          busy_o, done_o, fail_o;
  logic [2:0]    fail_elem_o;
  logic [1:0]    fail_port_o;
`ifdef LUTRAM_BIST_ERRCNT_EN
  logic [7:0]    err_count_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lutram_march_bist #(.A_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .ram_we_o    (ram_we_o),
    .ram_d_o     (ram_d_o),
    .ram_a_o     (ram_a_o),
    .ram_dpra_o  (ram_dpra_o),
    .ram_spo_i   (ram_spo_i),
    .ram_dpo_i   (ram_dpo_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_elem_o (fail_elem_o),
    .fail_addr_o (fail_addr_o),
    .fail_port_o (fail_port_o)
`ifdef LUTRAM_BIST_ERRCNT_EN
    ,
    .err_count_o (err_count_o)
`endif
  );

  // RAM model with an optional stuck-at value on either read port at one address.
  logic          mem [DEPTH];
  bit            f_spo, f_dpo, f_val;
  logic [AW-1:0] f_addr;

  always @(posedge clk) if (ram_we_o) mem[ram_a_o] <= ram_d_o;

  always_comb begin
    ram_spo_i = (f_spo && ram_a_o == f_addr)    ? f_val : mem[ram_a_o];
    ram_dpo_i = (f_dpo && ram_dpra_o == f_addr) ? f_val : mem[ram_dpra_o];
  end

  // Golden March C- cycle list.
  typedef struct {
    bit            we;
    bit            d;
    logic [AW-1:0] a;
    bit            rd;
    bit            exp;
    logic [2:0]    elem;
  } op_t;
  op_t golden[$];

  task automatic build_golden();
    bit up;
    int a;
    golden.delete();
    for (int i = 0; i < int'(DEPTH); i++) golden.push_back('{1'b1, 1'b0, AW'(i), 1'b0, 1'b0, 3'd0});
    for (int e = 1; e <= 4; e++) begin
      up = (e <= 2);
      for (int i = 0; i < int'(DEPTH); i++) begin
        a = up ? i : int'(DEPTH) - 1 - i;
        golden.push_back('{1'b0, 1'b0, AW'(a), 1'b1, (e % 2 == 0), 3'(e)});
        golden.push_back('{1'b1, (e % 2 == 1), AW'(a), 1'b0, 1'b0, 3'(e)});
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) golden.push_back('{1'b0, 1'b0, AW'(i), 1'b1, 1'b0, 3'd5});
  endtask

  // Outcome of a run under the current fault, from the golden read list.
  task automatic predict(output int busy, output bit fl, output logic [2:0] el,
                         output logic [AW-1:0] ad, output logic [1:0] pt, output int err);
    bit sb, db, stopped;
    busy = TOTAL; fl = 0; el = 0; ad = 0; pt = 0; err = 0; stopped = 0;
    for (int i = 0; i < golden.size(); i++) begin
      if (!stopped && golden[i].rd) begin
        sb = f_spo && golden[i].a == f_addr && f_val != golden[i].exp;
        db = f_dpo && golden[i].a == f_addr && f_val != golden[i].exp;
        if (sb || db) begin
          if (err < 255) err++;
          if (!fl) begin
            fl = 1; el = golden[i].elem; ad = golden[i].a; pt = {db, sb};
`ifndef LUTRAM_BIST_ERRCNT_EN
            busy = i + 1;
            stopped = 1;
`endif
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start a run, follow it cycle by cycle against the golden list, then check the DONE outputs.
  task automatic run_march(input string tag, input bit hold, input int e_busy, input bit e_fail,
                           input logic [2:0] e_elem, input logic [AW-1:0] e_addr,
                           input logic [1:0] e_port, input int e_err);
    int idx;
    bit seq_ok;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_i = 1'b0;
    idx = 0;
    seq_ok = 1;
    for (int c = 0; c < int'(TOTAL) + 10; c++) begin
      @(negedge clk);
      if (!busy_o) break;
      if (seq_ok && (idx >= golden.size() || done_o !== 1'b0 ||
                     ram_we_o !== golden[idx].we || ram_d_o !== golden[idx].d ||
                     ram_a_o !== golden[idx].a || ram_dpra_o !== ram_a_o)) begin
        seq_ok = 0;
        if (idx < golden.size())
          $display("FAIL seq_%s: cycle %0d got we=%b d=%b a=%0h dpra=%0h expected we=%b d=%b a=%0h",
                   tag, idx, ram_we_o, ram_d_o, ram_a_o, ram_dpra_o,
                   golden[idx].we, golden[idx].d, golden[idx].a);
        else
          $display("FAIL seq_%s: cycle %0d beyond end of march", tag, idx);
      end
      idx++;
    end
    n_checks++;
    if (!seq_ok) n_fail++;
    check({tag, "_busy_cycles"}, 32'(idx), 32'(e_busy));
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_we_idle"}, 32'({ram_we_o, ram_d_o}), 32'd0);
    if (idx > 0 && idx <= golden.size()) check({tag, "_addr_hold"}, 32'(ram_a_o), 32'(golden[idx-1].a));
    check({tag, "_fail"}, 32'(fail_o), 32'(e_fail));
    check({tag, "_fail_elem"}, 32'(fail_elem_o), 32'(e_elem));
    check({tag, "_fail_addr"}, 32'(fail_addr_o), 32'(e_addr));
    check({tag, "_fail_port"}, 32'(fail_port_o), 32'(e_port));
`ifdef LUTRAM_BIST_ERRCNT_EN
    check({tag, "_err_count"}, 32'(err_count_o), 32'(e_err));
`else
    if (e_err < 0) $display("negative error count %0d", e_err);
`endif
  endtask

  typedef struct {
    bit            spo;
    bit            dpo;
    logic [AW-1:0] fa;
    bit            fv;
    bit            e_fail;
    logic [2:0]    e_elem;
    logic [AW-1:0] e_addr;
    logic [1:0]    e_port;
    int            e_err;
    int            e_busy_stop;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            eb, ee, n;
    bit            efl;
    logic [2:0]    eel;
    logic [AW-1:0] ead;
    logic [1:0]    ept;
    int unsigned   port;

    tbl[0] = '{0, 0, 7'h00, 0, 0, 3'd0, 7'h00, 2'b00, 0, TOTAL};
    tbl[1] = '{1, 0, 7'h25, 1, 1, 3'd1, 7'h25, 2'b01, 3, 203};
    tbl[2] = '{0, 1, 7'h7F, 1, 1, 3'd1, 7'h7F, 2'b10, 3, 383};
    tbl[3] = '{1, 0, 7'h10, 0, 1, 3'd2, 7'h10, 2'b01, 2, 417};
    tbl[4] = '{1, 1, 7'h00, 1, 1, 3'd1, 7'h00, 2'b11, 3, 129};
    tbl[5] = '{0, 1, 7'h7F, 0, 1, 3'd2, 7'h7F, 2'b10, 2, 639};

    build_golden();
    f_spo = 0; f_dpo = 0; f_val = 0; f_addr = '0;
    rst_ni = 1'b0;
    start_i = 1'b0;

    // Reset, then idle with start low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("idle_outputs", 32'({ram_we_o, ram_d_o, ram_a_o, ram_dpra_o, busy_o, done_o,
                                 fail_o, fail_elem_o, fail_addr_o, fail_port_o}), 32'd0);
`ifdef LUTRAM_BIST_ERRCNT_EN
      check("idle_err_count", 32'(err_count_o), 32'd0);
`endif
      @(negedge clk);
    end

    // Hand-derived fault table.
    for (int i = 0; i < 6; i++) begin
      f_spo = tbl[i].spo; f_dpo = tbl[i].dpo; f_addr = tbl[i].fa; f_val = tbl[i].fv;
`ifdef LUTRAM_BIST_ERRCNT_EN
      eb = TOTAL;
`else
      eb = tbl[i].e_busy_stop;
`endif
      run_march($sformatf("tbl%0d", i), 1'b0, eb, tbl[i].e_fail, tbl[i].e_elem,
                tbl[i].e_addr, tbl[i].e_port, tbl[i].e_err);
    end

    // Random faults against the model.
    for (int r = 0; r < 8; r++) begin
      port   = $urandom_range(0, 3);
      f_spo  = port[0];
      f_dpo  = port[1];
      f_addr = AW'($urandom_range(0, DEPTH - 1));
      f_val  = 1'($urandom_range(0, 1));
      predict(eb, efl, eel, ead, ept, ee);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_march($sformatf("rnd%0d", r), 1'b0, eb, efl, eel, ead, ept, ee);
    end

    // Reset in the middle of M3, then a clean run.
    f_spo = 0; f_dpo = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (699) @(negedge clk);
    check("m3_busy_before_reset", 32'(busy_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk);
    check("midreset_outputs", 32'({ram_we_o, ram_d_o, ram_a_o, busy_o, done_o, fail_o}), 32'd0);
    rst_ni = 1'b1;
    run_march("after_reset", 1'b0, TOTAL, 1'b0, 3'd0, '0, 2'b00, 0);

    // start_i held high: faulted run, DONE for one cycle, then an automatic restart.
    f_spo = 1; f_dpo = 0; f_addr = 7'h25; f_val = 1;
    predict(eb, efl, eel, ead, ept, ee);
    run_march("held", 1'b1, eb, efl, eel, ead, ept, ee);
    @(negedge clk);
    check("restart_busy", 32'(busy_o), 32'd1);
    check("restart_fail_clr", 32'({fail_o, fail_port_o}), 32'd0);
    check("restart_we", 32'({ram_we_o, ram_a_o}), 32'({1'b1, 7'h00}));
    start_i = 1'b0;
    f_spo = 0;
    n = 1;
    for (int c = 0; c < int'(TOTAL) + 10; c++) begin
      @(negedge clk);
      if (!busy_o) break;
      n++;
    end
    check("rerun_busy_cycles", 32'(n), 32'(TOTAL));
    check("rerun_done", 32'(done_o), 32'd1);
    check("rerun_fail", 32'(fail_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
